// File: rtl/dmem_store_buffer.sv
// Data-memory responder: sized stores are posted through a small FIFO and retired into a
// word RAM; loads are combinational. Define DMEM_FORWARD_EN to overlay pending stores on loads.
module dmem_store_buffer #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                d_addr,
    input  logic [31:0]                d_mem_in,
    input  logic [1:0]                 write_data_size,
    input  logic                       d_mem_wen,
    output logic [31:0]                d_mem_out,
    output logic [$clog2(BUF_DEPTH):0] buf_count,
    output logic                       misalign_err
);

    localparam int unsigned PtrW  = $clog2(BUF_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned Words = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        SzNone = 2'd0,
        SzByte = 2'd1,
        SzHalf = 2'd2,
        SzWord = 2'd3
    } size_e;

    // Request decode
    logic [ADDR_WIDTH-1:0] req_waddr;
    logic [1:0]            req_off;
    logic                  store_req;
    logic                  store_aligned;
    logic                  accept;
    logic [3:0]            req_mask;
    logic [31:0]           req_data;
    logic                  unused_addr;

    // Buffer state
    logic [ADDR_WIDTH-1:0] ent_addr_q [BUF_DEPTH];
    logic [3:0]            ent_mask_q [BUF_DEPTH];
    logic [31:0]           ent_data_q [BUF_DEPTH];
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  misalign_q, misalign_d;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  drain;

    // Storage
    logic [31:0] mem_q [Words];
    logic [31:0] ram_word;
    logic [31:0] load_word;

    assign req_waddr   = d_addr[ADDR_WIDTH+1:2];
    assign req_off     = d_addr[1:0];
    assign unused_addr = ^d_addr[31:ADDR_WIDTH+2];

    always_comb begin
        store_req     = d_mem_wen && (write_data_size != SzNone);
        store_aligned = 1'b0;
        req_mask      = 4'b0000;
        case (size_e'(write_data_size))
            SzByte: begin
                store_aligned = 1'b1;
                req_mask      = 4'b0001 << req_off;
            end
            SzHalf: begin
                store_aligned = ~req_off[0];
                req_mask      = 4'b0011 << req_off;
            end
            SzWord: begin
                store_aligned = (req_off == 2'b00);
                req_mask      = 4'b1111;
            end
            default: begin
                store_aligned = 1'b0;
                req_mask      = 4'b0000;
            end
        endcase
        // Data is moved onto its lanes; the mask discards whatever lands outside them.
        req_data = d_mem_in << {req_off, 3'b000};
        accept   = store_req && store_aligned;
    end

    assign buf_full  = (count_q == CntW'(BUF_DEPTH));
    assign buf_empty = (count_q == '0);
    // When full, the head retires on the same edge that a new entry lands, so nothing is lost.
    assign drain     = !buf_empty && (!accept || buf_full);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = store_req && !store_aligned;
        if (drain) begin
            head_d = head_q + PtrW'(1);
        end
        if (accept) begin
            tail_d = tail_q + PtrW'(1);
        end
        case ({accept, drain})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Entry payload needs no reset: validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            ent_addr_q[tail_q] <= req_waddr;
            ent_mask_q[tail_q] <= req_mask;
            ent_data_q[tail_q] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && drain) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (ent_mask_q[head_q][k]) begin
                    mem_q[ent_addr_q[head_q]][8*k +: 8] <= ent_data_q[head_q][8*k +: 8];
                end
            end
        end
    end

    assign ram_word = mem_q[req_waddr];

`ifdef DMEM_FORWARD_EN
    logic [PtrW-1:0] fwd_idx;

    // Walk oldest to newest so younger stores win on overlapping bytes.
    always_comb begin
        load_word = ram_word;
        fwd_idx   = head_q;
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            fwd_idx = head_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (ent_addr_q[fwd_idx] == req_waddr)) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (ent_mask_q[fwd_idx][k]) begin
                        load_word[8*k +: 8] = ent_data_q[fwd_idx][8*k +: 8];
                    end
                end
            end
        end
    end
`else
    assign load_word = ram_word;
`endif

    assign d_mem_out    = load_word << {d_addr[1:0], 3'b000};
    assign buf_count    = count_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer (default ADDR_WIDTH/BUF_DEPTH).
module tb_dmem_store_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_addr;
    logic [31:0] d_mem_in;
    logic [1:0]  write_data_size;
    logic        d_mem_wen;
    logic [31:0] d_mem_out;
    logic [2:0]  buf_count;
    logic        misalign_err;

    int checks = 0;
    int passes = 0;

`ifdef DMEM_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    dmem_store_buffer #(
        .ADDR_WIDTH(10),
        .BUF_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .d_addr         (d_addr),
        .d_mem_in       (d_mem_in),
        .write_data_size(write_data_size),
        .d_mem_wen      (d_mem_wen),
        .d_mem_out      (d_mem_out),
        .buf_count      (buf_count),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        assert (got === want) passes = passes + 1;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        d_mem_wen       = 1'b0;
        write_data_size = 2'd0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        d_addr          = addr;
        d_mem_in        = data;
        write_data_size = sz;
        d_mem_wen       = 1'b1;
        tick();
        d_mem_wen       = 1'b0;
        write_data_size = 2'd0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] want);
        d_addr = addr;
        #1;
        check(tag, d_mem_out, want);
    endtask

    initial begin
        rst_n           = 1'b0;
        d_addr          = '0;
        d_mem_in        = '0;
        write_data_size = 2'd0;
        d_mem_wen       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_count", 32'(buf_count), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);

        // Word store, drain, read back
        store(32'h10, 32'hDEADBEEF, 2'd3);
        check("sw_count", 32'(buf_count), 32'd1);
        idle(4);
        load_check("sw_load", 32'h10, 32'hDEADBEEF);
        check("sw_drained", 32'(buf_count), 32'd0);

        // Byte lane: upper bits of store data must be masked off
        store(32'h20, 32'h11223344, 2'd3);
        idle(1);
        store(32'h21, 32'h556677AA, 2'd1);
        check("sb_count", 32'(buf_count), 32'd1);
        idle(1);
        check("sb_drained", 32'(buf_count), 32'd0);
        load_check("sb_word", 32'h20, 32'h1122AA44);
        load_check("sb_off1", 32'h21, 32'h22AA4400);
        load_check("sb_off3", 32'h23, 32'h44000000);

        // Halfword with a pending entry (forwarding vs stale RAM)
        store(32'h30, 32'h01020304, 2'd3);
        idle(1);
        store(32'h32, 32'h1234BEEF, 2'd2);
        check("sh_count", 32'(buf_count), 32'd1);
        load_check("sh_pending", 32'h30, Fwd ? 32'hBEEF0304 : 32'h01020304);
        idle(1);
        load_check("sh_drained", 32'h30, 32'hBEEF0304);

        // Two pending entries to one word: newer byte must win
        store(32'h30, 32'hAAAAAAAA, 2'd3);
        store(32'h30, 32'h00000055, 2'd1);
        check("order_count", 32'(buf_count), 32'd2);
        load_check("order_pending", 32'h30, Fwd ? 32'hAAAAAA55 : 32'hBEEF0304);
        idle(2);
        load_check("order_drained", 32'h30, 32'hAAAAAA55);

        // Full buffer: back-to-back stores past capacity
        for (int i = 0; i < 6; i++) begin
            store(32'h40 + 32'(4 * i), 32'h10000000 + 32'(i), 2'd3);
            check($sformatf("full_count%0d", i), 32'(buf_count), (i < 3) ? 32'(i + 1) : 32'd4);
        end
        idle(4);
        check("full_drained", 32'(buf_count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            load_check($sformatf("full_word%0d", i), 32'h40 + 32'(4 * i),
                       32'h10000000 + 32'(i));
        end

        // Misaligned stores are dropped with a one-cycle pulse
        store(32'h00, 32'hCAFEF00D, 2'd3);
        store(32'h04, 32'h0BADBEEF, 2'd3);
        idle(2);
        store(32'h03, 32'h0000FFFF, 2'd2);
        check("mis_sh_pulse", 32'(misalign_err), 32'd1);
        check("mis_sh_count", 32'(buf_count), 32'd0);
        idle(1);
        check("mis_sh_clear", 32'(misalign_err), 32'd0);
        store(32'h06, 32'h12345678, 2'd3);
        check("mis_sw_pulse", 32'(misalign_err), 32'd1);
        check("mis_sw_count", 32'(buf_count), 32'd0);
        idle(1);
        check("mis_sw_clear", 32'(misalign_err), 32'd0);
        store(32'h00, 32'h00000000, 2'd0);
        check("size0_count", 32'(buf_count), 32'd0);
        check("size0_misalign", 32'(misalign_err), 32'd0);
        load_check("mis_ram0", 32'h00, 32'hCAFEF00D);
        load_check("mis_ram4", 32'h04, 32'h0BADBEEF);

        // Reset discards pending stores
        store(32'h60, 32'h00000000, 2'd3);
        store(32'h64, 32'h00000000, 2'd3);
        store(32'h68, 32'h00000000, 2'd3);
        idle(3);
        store(32'h60, 32'h11111111, 2'd3);
        store(32'h64, 32'h22222222, 2'd3);
        store(32'h68, 32'h33333333, 2'd3);
        check("rstmid_count_before", 32'(buf_count), 32'd3);
        rst_n = 1'b0;
        tick();
        check("rstmid_count", 32'(buf_count), 32'd0);
        rst_n = 1'b1;
        idle(3);
        check("rstmid_count_after", 32'(buf_count), 32'd0);
        load_check("rstmid_ram60", 32'h60, 32'h00000000);
        load_check("rstmid_ram64", 32'h64, 32'h00000000);
        load_check("rstmid_ram68", 32'h68, 32'h00000000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
